fp_sub_seq: RTL and testbench

FP_SUB_SEQ -- requirements
Module: fp_sub_seq

---
 rtl/fp_sub_seq.sv | 180 ++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (opa - opb).
// One operation at a time: operands are captured on an accepted start,
// walked through swap/align/add/normalize/round, and the packed result
// is presented with a one-cycle done pulse. Alignment and normalization
// move one bit per cycle, so latency depends on the operands.
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;          // minuend as captured
  logic [31:0] b_q, b_d;          // subtrahend with its sign already flipped
  logic        sign_q, sign_d;    // sign of the larger-magnitude operand
  logic        sub_q, sub_d;      // effective operation is a subtraction
  logic [7:0]  exp_q, exp_d;      // working exponent
  logic [7:0]  exp_dif_q, exp_dif_d;
  logic [26:0] lg_mant_q, lg_mant_d;
  logic [26:0] sm_mant_q, sm_mant_d;
  logic [27:0] sum_q, sum_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Magnitude ordering: exponent first, then fraction; a full tie keeps opa large.
  logic        a_big;
  logic        lg_sign;
  logic [7:0]  lg_exp, sm_exp;
  logic [22:0] lg_frac, sm_frac;

  assign a_big   = (a_q[30:23] > b_q[30:23]) ||
                   ((a_q[30:23] == b_q[30:23]) && (a_q[22:0] >= b_q[22:0]));
  assign lg_sign = a_big ? a_q[31]    : b_q[31];
  assign lg_exp  = a_big ? a_q[30:23] : b_q[30:23];
  assign lg_frac = a_big ? a_q[22:0]  : b_q[22:0];
  assign sm_exp  = a_big ? b_q[30:23] : a_q[30:23];
  assign sm_frac = a_big ? b_q[22:0]  : a_q[22:0];

  // Round-to-nearest-even on the guard/round/sticky bits, then pack.
  // mant is the normalized 27-bit value with the hidden one at bit 26.
  function automatic logic [31:0] round_pack(input logic sign, input logic [7:0] exp,
                                             input logic [26:0] mant);
    logic        inc;
    logic [24:0] m;
    logic [7:0]  e;
    inc = (mant[2:0] > 3'b100) || ((mant[2:0] == 3'b100) && mant[3]);
    m   = {1'b0, mant[26:3]} + {24'd0, inc};
    e   = m[24] ? (exp + 8'd1) : exp;
    return {sign, e, (m[24] ? 23'd0 : m[22:0])};
  endfunction

  // Next-state and datapath update for every step of the operation.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    exp_d     = exp_q;
    exp_dif_d = exp_dif_q;
    lg_mant_d = lg_mant_q;
    sm_mant_d = sm_mant_q;
    sum_d     = sum_q;
    result_d  = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = opa;
          b_d     = {~opb[31], opb[30:0]};
          state_d = SWAP;
        end else begin
          state_d = IDLE;
        end
      end
      // ---- swap: order operands, build guarded mantissas ----
      SWAP: begin
        sign_d    = lg_sign;
        sub_d     = a_q[31] ^ b_q[31];
        exp_d     = lg_exp;
        exp_dif_d = lg_exp - sm_exp;
        lg_mant_d = {1'b1, lg_frac, 3'b000};
        sm_mant_d = {1'b1, sm_frac, 3'b000};
        state_d   = (lg_exp == sm_exp) ? ADD : ALIGN;
      end
      // ---- align: one bit per cycle, shifted-out bits kept as sticky ----
      ALIGN: begin
        if (exp_dif_q > 8'd26) begin
          sm_mant_d = 27'd1;
          exp_dif_d = 8'd0;
          state_d   = ADD;
        end else begin
          sm_mant_d = {1'b0, sm_mant_q[26:2], sm_mant_q[1] | sm_mant_q[0]};
          exp_dif_d = exp_dif_q - 8'd1;
          if (exp_dif_q == 8'd1) state_d = ADD;
        end
      end
      // ---- add: large +/- small, never negative ----
      ADD: begin
        sum_d   = sub_q ? ({1'b0, lg_mant_q} - {1'b0, sm_mant_q})
                        : ({1'b0, lg_mant_q} + {1'b0, sm_mant_q});
        state_d = NORM;
      end
      // ---- normalize: carry out, exact zero, or left shift toward bit 26 ----
      NORM: begin
        if (sum_q[27]) begin
          sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 8'd1;
          state_d = ROUND;
        end else if (sum_q == 28'd0) begin
          result_d = 32'h0000_0000;
          state_d  = DONE;
        end else if (sum_q[26]) begin
          state_d = ROUND;
        end else begin
          sum_d = {sum_q[26:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      // ---- round: RNE and pack into the result register ----
      ROUND: begin
        result_d = round_pack(sign_q, exp_q, sum_q[26:0]);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the state being entered.
  always_comb begin
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // All state, including the datapath, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sign_q    <= 1'b0;
      sub_q     <= 1'b0;
      exp_q     <= 8'd0;
      exp_dif_q <= 8'd0;
      lg_mant_q <= 27'd0;
      sm_mant_q <= 27'd0;
      sum_q     <= 28'd0;
      result_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      sub_q     <= sub_d;
      exp_q     <= exp_d;
      exp_dif_q <= exp_dif_d;
      lg_mant_q <= lg_mant_d;
      sm_mant_q <= sm_mant_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: an exact-arithmetic reference model predicts the
// result and the completion edge of every accepted operation; a per-cycle
// compare process checks busy, done and result against that schedule.
module tb_fp_sub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  fp_sub_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opa    (opa),
    .opb    (opb),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: exact difference of the two values as wide integers, rounded
  // to 24 significant bits with ties to even. Latency derives from the
  // exponent gap (alignment) and where the exact difference's leading one
  // sits relative to the larger operand's 27-bit grid (normalization).
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic [31:0]  be;
    logic [127:0] va, vb, mag, keep, rem, half;
    logic         sgn, up;
    int           ea, eb, emin, emax, dif, p, sh, e, A, N, k;
    be   = {~b[31], b[30:0]};
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    emax = (ea < eb) ? eb : ea;
    dif  = emax - emin;
    va   = {104'd0, 1'b1, a[22:0]} << (ea - emin);
    vb   = {104'd0, 1'b1, be[22:0]} << (eb - emin);
    if (a[31] == be[31]) begin mag = va + vb; sgn = a[31]; end
    else if (va >= vb)   begin mag = va - vb; sgn = a[31]; end
    else                 begin mag = vb - va; sgn = be[31]; end
    A = (dif == 0) ? 0 : ((dif > 26) ? 1 : dif);
    if (mag == 128'd0) begin
      res = 32'h0000_0000;
      lat = 3 + A;
      return;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (p <= 23) begin
      keep = mag << (23 - p);
    end else begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && keep[0]);
      if (up) keep = keep + 128'd1;
      if (keep == (128'd1 << 24)) begin
        keep = keep >> 1;
        e    = e + 1;
      end
    end
    res = {sgn, 8'(e), keep[22:0]};
    k   = p - dif + 3;
    N   = (k >= 26) ? 1 : 1 + (26 - k);
    lat = 3 + A + N;
  endfunction

  // Transaction schedule predicted by the model, advanced on every rising edge.
  int          ecount   = 0;
  int          m_acc    = -100;
  int          m_done   = -100;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pending = 32'd0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) begin
    logic [31:0] r;
    int          l;
    ecount = ecount + 1;
    if (rst) begin
      m_acc    = -100;
      m_done   = -100;
      m_result = 32'd0;
    end else begin
      if (ecount == m_done) m_result = m_pending;
      if (start && !((ecount - 1 >= m_acc) && (ecount - 1 < m_done))) begin
        model(opa, opb, r, l);
        m_pending = r;
        m_acc     = ecount;
        m_done    = ecount + l;
      end
    end
  end

  // Per-cycle comparison of all outputs against the predicted schedule.
  always @(negedge clk) begin
    logic        exp_b, exp_d;
    logic [31:0] exp_r;
    if (chk_en) begin
      if (rst) begin
        exp_b = 1'b0; exp_d = 1'b0; exp_r = 32'd0;
      end else begin
        exp_b = (ecount >= m_acc) && (ecount < m_done);
        exp_d = (ecount == m_done);
        exp_r = m_result;
      end
      chk("cyc_busy",   32'(busy), 32'(exp_b));
      chk("cyc_done",   32'(done), 32'(exp_d));
      chk("cyc_result", result, exp_r);
    end
  end

  task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input int el);
    logic [31:0] r;
    int          l;
    model(a, b, r, l);
    chk({name, "_model_res"}, r, er);
    chk({name, "_model_lat"}, 32'(l), 32'(el));
  endtask

  // One directed operation from idle: literal result, latency, and one-cycle done.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el);
    int  k;
    bit  seen;
    @(negedge clk);
    start = 1'b1; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom;
    k = 1; seen = 1'b0;
    while (k < 100 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_res"}, result, er);
      chk({name, "_lat"}, 32'(k - 1), 32'(el));
      @(negedge clk);
      chk({name, "_done_1cyc"}, 32'(done), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(154, 100));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_partner(input logic [31:0] a);
    logic [31:0] r;
    logic [7:0]  e;
    r = rnd_fp();
    case ($urandom % 6)
      0: return a;
      1: return {~a[31], a[30:0]};
      2: return {r[31], a[30:23], r[22:0]};
      3: begin
        e = a[30:23] + 8'($urandom_range(3, 0)) - 8'd1;
        return {r[31], e, r[22:0]};
      end
      default: return r;
    endcase
  endfunction

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; opa = 32'd0; opb = 32'd0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    pin_model("m3m1",   32'h40400000, 32'h3F800000, 32'h40000000, 5);
    pin_model("m1m1",   32'h3F800000, 32'h3F800000, 32'h00000000, 3);
    pin_model("m2m3",   32'h40000000, 32'h40400000, 32'hBF800000, 5);
    pin_model("m1mn1",  32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    pin_model("m1ulp",  32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 29);
    pin_model("mtie",   32'h3F800000, 32'hB3800000, 32'h3F800000, 28);

    run_op("d3m1",  32'h40400000, 32'h3F800000, 32'h40000000, 5);
    run_op("d1m1",  32'h3F800000, 32'h3F800000, 32'h00000000, 3);
    run_op("d2m3",  32'h40000000, 32'h40400000, 32'hBF800000, 5);
    run_op("d1mn1", 32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    run_op("d1ulp", 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 29);
    run_op("dtie",  32'h3F800000, 32'hB3800000, 32'h3F800000, 28);
    run_op("d3m1b", 32'h40400000, 32'h3F800000, 32'h40000000, 5);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; opa = 32'h4B000000; opb = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_done",   32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 5);

    // Random operands with random start gaps.
    repeat (500) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      opa   = rnd_fp();
      opb   = rnd_partner(opa);
    end
    // Start held high; operands change every cycle.
    repeat (300) begin
      @(negedge clk);
      start = 1'b1;
      opa   = rnd_fp();
      opb   = rnd_partner(opa);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
